barrier_core_requester: RTL and testbench



---
 rtl/barrier_core_requester.sv | 157 +++++++++++++++
 tb/tb_barrier_core_requester.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/barrier_core_requester.sv
// Per-core client of the cluster hardware barrier: arrival pulse, clock gating while waiting, release response.
// Optional SLEEP timeout with forced error wake is enabled by defining BARRIER_REQ_TIMEOUT_EN.
module barrier_core_requester #(
    parameter int unsigned NUM_BARRIERS   = 8,
    parameter int unsigned BAR_ID_W       = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    core_req_i,
    input  logic [BAR_ID_W-1:0]     core_bar_id_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic                    core_err_o,
    output logic                    core_clock_en_o,
    output logic [NUM_BARRIERS-1:0] barrier_get_o,
    input  logic                    barrier_event_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARRIVE = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } state_e;

    localparam logic [31:0] NUM_BARRIERS_EXT = 32'(NUM_BARRIERS);

    function automatic logic [NUM_BARRIERS-1:0] id_onehot(input logic [BAR_ID_W-1:0] id);
        logic [NUM_BARRIERS-1:0] oh;
        oh = {{(NUM_BARRIERS-1){1'b0}}, 1'b1} << id;
        return oh;
    endfunction

    state_e                  state_r;
    state_e                  state_next_s;
    logic [BAR_ID_W-1:0]     id_r;
    logic [BAR_ID_W-1:0]     id_next_s;
    logic                    err_next_s;
    logic                    gnt_s;
    logic                    id_valid_s;
    logic                    timeout_hit_s;
    logic                    err_r;
    logic                    rvalid_r;
    logic                    clk_en_r;
    logic                    busy_r;
    logic [NUM_BARRIERS-1:0] get_r;

    // Zero-extended compare so non-power-of-two barrier counts reject the unused ids.
    assign id_valid_s = (32'(core_bar_id_i) < NUM_BARRIERS_EXT);

`ifdef BARRIER_REQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // SLEEP-cycle counter; held at zero outside SLEEP so every entry starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_SLEEP) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    assign timeout_hit_s = (tmo_cnt_r == TMO_LAST);
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign timeout_hit_s    = 1'b0;
`endif

    // Next-state, id latch and error qualification.
    always_comb begin
        state_next_s = state_r;
        id_next_s    = id_r;
        err_next_s   = 1'b0;
        gnt_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                gnt_s = core_req_i;
                if (core_req_i) begin
                    id_next_s = core_bar_id_i;
                    if (id_valid_s) begin
                        state_next_s = ST_ARRIVE;
                    end else begin
                        state_next_s = ST_WAKE;
                        err_next_s   = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARRIVE: begin
                // Last arriver: the barrier releases in the same cycle as our get.
                if (barrier_event_i) begin
                    state_next_s = ST_WAKE;
                end else begin
                    state_next_s = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (barrier_event_i) begin
                    state_next_s = ST_WAKE;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_WAKE;
                    err_next_s   = 1'b1;
                end else begin
                    state_next_s = ST_SLEEP;
                end
            end
            ST_WAKE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next state, so each is a clean flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            id_r     <= {BAR_ID_W{1'b0}};
            err_r    <= 1'b0;
            rvalid_r <= 1'b0;
            clk_en_r <= 1'b1;
            busy_r   <= 1'b0;
            get_r    <= {NUM_BARRIERS{1'b0}};
        end else begin
            state_r  <= state_next_s;
            id_r     <= id_next_s;
            err_r    <= err_next_s && (state_next_s == ST_WAKE);
            rvalid_r <= (state_next_s == ST_WAKE);
            clk_en_r <= (state_next_s != ST_SLEEP);
            busy_r   <= (state_next_s != ST_IDLE);
            if (state_next_s == ST_ARRIVE) begin
                get_r <= id_onehot(id_next_s);
            end else begin
                get_r <= {NUM_BARRIERS{1'b0}};
            end
        end
    end

    assign core_gnt_o      = gnt_s;
    assign core_rvalid_o   = rvalid_r;
    assign core_err_o      = err_r;
    assign core_clock_en_o = clk_en_r;
    assign barrier_get_o   = get_r;
    assign busy_o          = busy_r;

endmodule

// File: tb/tb_barrier_core_requester.sv
// Directed bench for barrier_core_requester (6 barriers, 16-cycle timeout when BARRIER_REQ_TIMEOUT_EN is defined).
module tb_barrier_core_requester;

    localparam int NB  = 6;
    localparam int TMO = 16;
    localparam int NEVER = 1000000;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          core_req_i = 1'b0;
    logic [2:0]    core_bar_id_i = 3'd0;
    logic          core_gnt_o;
    logic          core_rvalid_o;
    logic          core_err_o;
    logic          core_clock_en_o;
    logic [NB-1:0] barrier_get_o;
    logic          barrier_event_i = 1'b0;
    logic          busy_o;

    int checks = 0;
    int failures = 0;

    barrier_core_requester #(
        .NUM_BARRIERS   (NB),
        .BAR_ID_W       (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .core_req_i      (core_req_i),
        .core_bar_id_i   (core_bar_id_i),
        .core_gnt_o      (core_gnt_o),
        .core_rvalid_o   (core_rvalid_o),
        .core_err_o      (core_err_o),
        .core_clock_en_o (core_clock_en_o),
        .barrier_get_o   (barrier_get_o),
        .barrier_event_i (barrier_event_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a request lives for a number of cycles ("age"), released at a known age.
    bit         m_active = 1'b0;
    int         m_age = 0;
    int         m_wake_at = NEVER;
    logic [2:0] m_id = 3'd0;
    bit         m_err = 1'b0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_wake_at <= NEVER;
            m_err    <= 1'b0;
        end else if (m_active) begin
            if (m_age == m_wake_at) begin
                m_active <= 1'b0;
            end else begin
                m_age <= m_age + 1;
                if (barrier_event_i) begin
                    m_wake_at <= m_age + 1;
                end
`ifdef BARRIER_REQ_TIMEOUT_EN
                else if (m_age >= 2 && (m_age - 2) == TMO - 1) begin
                    m_wake_at <= m_age + 1;
                    m_err     <= 1'b1;
                end
`endif
            end
        end else if (core_req_i) begin
            m_active  <= 1'b1;
            m_age     <= 1;
            m_id      <= core_bar_id_i;
            m_err     <= (int'(core_bar_id_i) >= NB);
            m_wake_at <= (int'(core_bar_id_i) >= NB) ? 1 : NEVER;
        end
    end

    always @(negedge clk_i) begin
        logic          e_gnt, e_rv, e_err, e_ce, e_busy;
        logic [NB-1:0] e_get;
        e_gnt = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_ce = 1'b1; e_busy = 1'b0;
        e_get = '0;
        if (!rst_ni) begin
            e_gnt = 1'b0;
        end else if (!m_active) begin
            e_gnt = core_req_i;
        end else if (m_age == m_wake_at) begin
            e_rv = 1'b1; e_err = m_err; e_busy = 1'b1;
        end else if (m_age == 1) begin
            e_get = NB'(1) << m_id; e_busy = 1'b1;
        end else begin
            e_ce = 1'b0; e_busy = 1'b1;
        end
        cmp("m_gnt", 32'(core_gnt_o), 32'(e_gnt));
        cmp("m_rvalid", 32'(core_rvalid_o), 32'(e_rv));
        cmp("m_err", 32'(core_err_o), 32'(e_err));
        cmp("m_clock_en", 32'(core_clock_en_o), 32'(e_ce));
        cmp("m_busy", 32'(busy_o), 32'(e_busy));
        cmp("m_get", 32'(barrier_get_o), 32'(e_get));
    end

    task automatic cyc(input logic req, input logic [2:0] id, input logic ev);
        @(posedge clk_i);
        #1;
        core_req_i = req;
        core_bar_id_i = id;
        barrier_event_i = ev;
        @(negedge clk_i);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        cmp("rst_clock_en", 32'(core_clock_en_o), 32'd1);
        cmp("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Normal release: id 3, event at cycle 10
        cyc(1'b1, 3'd3, 1'b0);
        cmp("norm_gnt_c0", 32'(core_gnt_o), 32'd1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("norm_get_c1", 32'(barrier_get_o), 32'b001000);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("norm_ce_c2", 32'(core_clock_en_o), 32'd0);
        repeat (7) cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("norm_rvalid_c11", 32'(core_rvalid_o), 32'd1);
        cmp("norm_err_c11", 32'(core_err_o), 32'd0);
        cmp("norm_ce_c11", 32'(core_clock_en_o), 32'd1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("norm_busy_c12", 32'(busy_o), 32'd0);

        // Last arriver: event during ARRIVE
        cyc(1'b1, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1);
        cmp("last_get_c1", 32'(barrier_get_o), 32'b000001);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("last_rvalid_c2", 32'(core_rvalid_o), 32'd1);
        cmp("last_ce_c2", 32'(core_clock_en_o), 32'd1);

        // Invalid ids 7 and 6
        cyc(1'b1, 3'd7, 1'b0);
        cmp("inv_gnt_c0", 32'(core_gnt_o), 32'd1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("inv_rvalid_c1", 32'(core_rvalid_o), 32'd1);
        cmp("inv_err_c1", 32'(core_err_o), 32'd1);
        cmp("inv_get_c1", 32'(barrier_get_o), 32'd0);
        cyc(1'b1, 3'd6, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("inv6_err", 32'(core_err_o), 32'd1);
        cyc(1'b0, 3'd0, 1'b0);

        // Reset in SLEEP, then a normal id 1 request
        cyc(1'b1, 3'd4, 1'b0);
        repeat (3) cyc(1'b0, 3'd0, 1'b0);
        cmp("rs_ce_sleep", 32'(core_clock_en_o), 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        cmp("rs_ce_async", 32'(core_clock_en_o), 32'd1);
        cmp("rs_busy_async", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("rs_get_id1", 32'(barrier_get_o), 32'b000010);
        cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("rs_rvalid", 32'(core_rvalid_o), 32'd1);

        // Stray events in IDLE
        repeat (3) cyc(1'b0, 3'd2, 1'b1);
        cmp("stray_busy", 32'(busy_o), 32'd0);
        cmp("stray_rvalid", 32'(core_rvalid_o), 32'd0);

        // Back-to-back: id 2 then id 5, core holds req
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd5, 1'b0);
        cmp("b2b_get2", 32'(barrier_get_o), 32'b000100);
        cmp("b2b_nognt_arrive", 32'(core_gnt_o), 32'd0);
        cyc(1'b1, 3'd5, 1'b0);
        cyc(1'b1, 3'd5, 1'b1);
        cyc(1'b1, 3'd5, 1'b0);
        cmp("b2b_rvalid1", 32'(core_rvalid_o), 32'd1);
        cmp("b2b_nognt_wake", 32'(core_gnt_o), 32'd0);
        cyc(1'b1, 3'd5, 1'b0);
        cmp("b2b_gnt2", 32'(core_gnt_o), 32'd1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("b2b_get5", 32'(barrier_get_o), 32'b100000);
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("b2b_rvalid2", 32'(core_rvalid_o), 32'd1);
        cyc(1'b0, 3'd0, 1'b0);

`ifdef BARRIER_REQ_TIMEOUT_EN
        // Expiry with no event: 16 SLEEP cycles, then error wake
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        repeat (16) cyc(1'b0, 3'd0, 1'b0);
        cmp("tmo_ce_last_sleep", 32'(core_clock_en_o), 32'd0);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("tmo_rvalid", 32'(core_rvalid_o), 32'd1);
        cmp("tmo_err", 32'(core_err_o), 32'd1);
        cyc(1'b0, 3'd0, 1'b0);
        // Event on the expiry cycle wins
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        repeat (15) cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("tmo_ev_rvalid", 32'(core_rvalid_o), 32'd1);
        cmp("tmo_ev_err", 32'(core_err_o), 32'd0);
`else
        // Long sleep: no timeout exists, core stays gated
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        repeat (24) cyc(1'b0, 3'd0, 1'b0);
        cmp("long_ce", 32'(core_clock_en_o), 32'd0);
        cmp("long_rvalid", 32'(core_rvalid_o), 32'd0);
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b0, 3'd0, 1'b0);
        cmp("long_rvalid_end", 32'(core_rvalid_o), 32'd1);
        cmp("long_err_end", 32'(core_err_o), 32'd0);
`endif
        repeat (3) cyc(1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
